// File: rtl/fir_axil_pkg.sv
// rtl/fir_axil_pkg.sv - Register map, ap_ctrl bit positions and read-path states for fir_axil_ctrl.
package fir_axil_pkg;

  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_DATA_LEN = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BRAM,
    RD_RESP
  } rd_state_e;

  function automatic int tap_last_addr(input int taps);
    return ADDR_TAP_BASE + 4 * (taps - 1);
  endfunction

endpackage

// File: rtl/fir_axil_if.sv
// rtl/fir_axil_if.sv - AXI4-Lite configuration bus (AW/W/AR/R, no B channel) between host and fir_axil_ctrl.
interface fir_axil_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) ();

  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );

endinterface

// File: rtl/fir_axil_ctrl.sv
// rtl/fir_axil_ctrl.sv - AXI-Lite register responder, ap_ctrl/data_length and tap BRAM port arbitration.
// Define FIR_AXIL_CFG_LOCK_EN to drop config/tap writes (and zero tap reads) while the engine runs.
module fir_axil_ctrl
  import fir_axil_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_axil_if.slave              axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start_o,
  input  logic                   eng_done_i,
  output logic [pDATA_WIDTH-1:0] data_length_o
);

`ifdef FIR_AXIL_CFG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  localparam int TAP_LAST = tap_last_addr(Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP  = pADDR_WIDTH'(ADDR_TAP_BASE);

  function automatic logic in_tap(input logic [pADDR_WIDTH-1:0] a);
    return (32'(a) >= 32'(ADDR_TAP_BASE)) && (32'(a) <= 32'(TAP_LAST));
  endfunction

  logic                   wr_rdy_q, wr_rdy_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic                   tap_en_q, tap_en_d;
  logic [3:0]             tap_we_q, tap_we_d;
  logic [pADDR_WIDTH-1:0] tap_a_q, tap_a_d;
  logic [pDATA_WIDTH-1:0] tap_di_q, tap_di_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  rd_state_e              rd_state_q, rd_state_d;
  logic [pADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                   rd_tap_q, rd_tap_d;
  logic                   clr_done_q, clr_done_d;

  logic                   busy, aw_tap, ar_tap, wr_acc, wr_tap, rd_acc, rd_tap_live;
  logic [pDATA_WIDTH-1:0] reg_val;

  always_comb begin
    // A start that has been accepted but not yet dropped ap_idle already owns the engine.
    busy        = !ap_idle_q || ap_start_q;
    aw_tap      = in_tap(axil.awaddr);
    ar_tap      = in_tap(axil.araddr);
    wr_acc      = axil.awvalid && axil.wvalid && !wr_rdy_q && !(aw_tap && busy && !LOCK);
    wr_tap      = wr_acc && aw_tap && !busy;
    rd_tap_live = ar_tap && !busy;
    rd_acc      = (rd_state_q == RD_IDLE) && !arready_q && axil.arvalid &&
                  !(ar_tap && (wr_tap || (busy && !LOCK)));

    reg_val = '0;
    if (rd_addr_q == A_CTRL) begin
      reg_val[AP_START_BIT] = ap_start_q;
      reg_val[AP_DONE_BIT]  = ap_done_q;
      reg_val[AP_IDLE_BIT]  = ap_idle_q;
    end else if (rd_addr_q == A_LEN) begin
      reg_val = data_length_q;
    end

    wr_rdy_d      = 1'b0;
    ap_start_d    = 1'b0;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    data_length_d = data_length_q;
    tap_en_d      = 1'b0;
    tap_we_d      = 4'h0;
    tap_a_d       = tap_a_q;
    tap_di_d      = tap_di_q;
    arready_d     = 1'b0;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    rd_tap_d      = rd_tap_q;
    clr_done_d    = clr_done_q;

    if (wr_acc) begin
      wr_rdy_d = 1'b1;
      if (axil.awaddr == A_CTRL) begin
        ap_start_d = axil.wdata[AP_START_BIT] && !busy;
      end else if (axil.awaddr == A_LEN) begin
        if (!(LOCK && busy)) data_length_d = axil.wdata;
      end else if (wr_tap) begin
        tap_en_d = 1'b1;
        tap_we_d = 4'hF;
        tap_a_d  = axil.awaddr - A_TAP;
        tap_di_d = axil.wdata;
      end
    end

    // Tap reads hit the BRAM during the arready cycle so data lands one cycle later.
    if (rd_acc) begin
      arready_d = 1'b1;
      rd_addr_d = axil.araddr;
      rd_tap_d  = rd_tap_live;
      if (rd_tap_live) begin
        tap_en_d = 1'b1;
        tap_a_d  = axil.araddr - A_TAP;
      end
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (arready_q) begin
          if (rd_tap_q) begin
            rd_state_d = RD_BRAM;
          end else begin
            rdata_d    = reg_val;
            rvalid_d   = 1'b1;
            clr_done_d = (rd_addr_q == A_CTRL) && ap_done_q;
            rd_state_d = RD_RESP;
          end
        end
      end
      RD_BRAM: begin
        rdata_d    = tap_Do;
        rvalid_d   = 1'b1;
        rd_state_d = RD_RESP;
      end
      RD_RESP: begin
        if (axil.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
          if (clr_done_q) ap_done_d = 1'b0;
          clr_done_d = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (ap_start_q) ap_idle_d = 1'b0;
    if (eng_done_i) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      wr_rdy_q      <= 1'b0;
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      data_length_q <= '0;
      tap_en_q      <= 1'b0;
      tap_we_q      <= 4'h0;
      tap_a_q       <= '0;
      tap_di_q      <= '0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rd_state_q    <= RD_IDLE;
      rd_addr_q     <= '0;
      rd_tap_q      <= 1'b0;
      clr_done_q    <= 1'b0;
    end else begin
      wr_rdy_q      <= wr_rdy_d;
      ap_start_q    <= ap_start_d;
      ap_done_q     <= ap_done_d;
      ap_idle_q     <= ap_idle_d;
      data_length_q <= data_length_d;
      tap_en_q      <= tap_en_d;
      tap_we_q      <= tap_we_d;
      tap_a_q       <= tap_a_d;
      tap_di_q      <= tap_di_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rd_state_q    <= rd_state_d;
      rd_addr_q     <= rd_addr_d;
      rd_tap_q      <= rd_tap_d;
      clr_done_q    <= clr_done_d;
    end
  end

  assign axil.awready  = wr_rdy_q;
  assign axil.wready   = wr_rdy_q;
  assign axil.arready  = arready_q;
  assign axil.rvalid   = rvalid_q;
  assign axil.rdata    = rdata_q;
  assign ap_start_o    = ap_start_q;
  assign data_length_o = data_length_q;
  assign tap_Di        = tap_di_q;

  always_comb begin
    if (ap_idle_q) begin
      tap_EN = tap_en_q;
      tap_WE = tap_we_q;
      tap_A  = tap_a_q;
    end else begin
      tap_EN = eng_tap_EN;
      tap_WE = 4'h0;
      tap_A  = eng_tap_A;
    end
  end

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// tb/tb_fir_axil_ctrl.sv - Directed scoreboard bench for fir_axil_ctrl (honours FIR_AXIL_CFG_LOCK_EN).
module tb_fir_axil_ctrl;

`ifdef FIR_AXIL_CFG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        axis_rst_n;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic        eng_tap_EN;
  logic [11:0] eng_tap_A;
  logic        ap_start_o;
  logic        eng_done_i;
  logic [31:0] data_length_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0;
  int wr_hs_cyc, rd_hs_cyc;
  logic [48:0] wr_tap_obs;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:15];

  fir_axil_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axil ();

  fir_axil_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk      (clk),
    .axis_rst_n    (axis_rst_n),
    .axil          (axil),
    .tap_WE        (tap_WE),
    .tap_EN        (tap_EN),
    .tap_Di        (tap_Di),
    .tap_A         (tap_A),
    .tap_Do        (tap_Do),
    .eng_tap_EN    (eng_tap_EN),
    .eng_tap_A     (eng_tap_A),
    .ap_start_o    (ap_start_o),
    .eng_done_i    (eng_done_i),
    .data_length_o (data_length_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ap_start_o) start_cnt <= start_cnt + 1;

  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
    bit ok = 1'b0;
    @(posedge clk); #1;
    axil.awaddr = addr; axil.wdata = data; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (axil.awready && axil.wready) begin
        ok = 1'b1;
        wr_hs_cyc = cyc;
        wr_tap_obs = {tap_EN, tap_WE, tap_A, tap_Di};
      end
    end
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    if (!ok) check("wr_timeout", 64'(ok), 64'd1);
  endtask

  task automatic axil_read(input logic [11:0] addr, input logic [31:0] exp, input int lat,
                           input int hold, input bit done_at_beat);
    bit ok = 1'b0;
    int t = 0;
    logic [31:0] got = '0;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    axil.araddr = addr; axil.arvalid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (axil.arready) begin ok = 1'b1; t = cyc; rd_hs_cyc = cyc; end
    end
    @(posedge clk); #1;
    axil.arvalid = 1'b0;
    if (!ok) begin
      check("ar_timeout", 64'(ok), 64'd1);
      void'(exp_q.pop_front());
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (axil.rvalid) begin
        ok = 1'b1;
        got = axil.rdata;
        check("rd_latency", 64'(cyc - t), 64'(lat));
      end
    end
    if (!ok) begin
      check("r_timeout", 64'(ok), 64'd1);
      void'(exp_q.pop_front());
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rd_hold", {31'd0, axil.rvalid, axil.rdata}, {31'd0, 1'b1, exp});
    end
    axil.rready = 1'b1;
    eng_done_i = done_at_beat;
    @(posedge clk); #1;
    axil.rready = 1'b0;
    eng_done_i = 1'b0;
    e = exp_q.pop_front();
    check("rd_data", 64'(got), 64'(e));
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 eng_done_i = 1'b1;
    @(posedge clk); #1 eng_done_i = 1'b0;
  endtask

  initial begin
    int taps[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int s0;
    bit seen;
    axis_rst_n = 1'b1;
    axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0; axil.rready = 0;
    axil.awaddr = '0; axil.wdata = '0; axil.araddr = '0;
    eng_tap_EN = 0; eng_tap_A = '0; eng_done_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 64'({axil.awready, axil.wready, axil.arready, axil.rvalid, ap_start_o, tap_EN, tap_WE, tap_A}), 64'd0);
    check("reset_data", {axil.rdata, data_length_o}, 64'd0);
    @(posedge clk); #1 axis_rst_n = 1'b0;

    axil_read(12'h000, 32'h4, 1, 0, 0);
    axil_write(12'h010, 32'd600);
    check("data_length_o", 64'(data_length_o), 64'd600);
    axil_read(12'h010, 32'd600, 1, 0, 0);

    for (int i = 0; i < 11; i++) begin
      axil_write(12'h020 + 12'(4 * i), 32'(taps[i]));
      check("tap_wr_strobe", 64'(wr_tap_obs), 64'({1'b1, 4'hF, 12'(4 * i), 32'(taps[i])}));
    end
    for (int i = 0; i < 11; i++) axil_read(12'h020 + 12'(4 * i), 32'(taps[i]), 2, 0, 0);
    axil_read(12'h004, 32'h0, 1, 0, 0);

    s0 = start_cnt;
    axil_write(12'h000, 32'h1);
    repeat (3) @(posedge clk);
    check("start_pulse", 64'(start_cnt - s0), 64'd1);
    axil_read(12'h000, 32'h0, 1, 0, 0);
    @(posedge clk); #1 eng_tap_EN = 1'b1; eng_tap_A = 12'h014;
    @(negedge clk);
    check("eng_mux", 64'({tap_EN, tap_WE, tap_A}), 64'({1'b1, 4'h0, 12'h014}));
    eng_tap_EN = 1'b0;
    axil_write(12'h000, 32'h1);
    repeat (3) @(posedge clk);
    check("busy_start_ignored", 64'(start_cnt - s0), 64'd1);

    @(posedge clk); #1;
    axil.awaddr = 12'h024; axil.wdata = 32'd5; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (axil.awready && !seen) begin
        seen = 1'b1;
        @(posedge clk); #1 axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      end
    end
    check("busy_tap_wr_hs", 64'(seen), 64'(LOCK));
    pulse_done();
    if (!seen) begin
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (axil.wready) seen = 1'b1;
      end
      @(posedge clk); #1 axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      check("stalled_tap_wr_hs", 64'(seen), 64'd1);
    end
    axil_read(12'h000, 32'h6, 1, 0, 0);
    axil_read(12'h000, 32'h4, 1, 0, 0);
    axil_read(12'h024, LOCK ? 32'hFFFF_FFF6 : 32'd5, 2, 0, 0);

    axil_write(12'h000, 32'h1);
    pulse_done();
    axil_read(12'h000, 32'h6, 1, 2, 1);
    axil_read(12'h000, 32'h6, 1, 0, 0);
    axil_read(12'h000, 32'h4, 1, 0, 0);

    fork
      axil_write(12'h028, 32'd77);
      axil_read(12'h02C, 32'd23, 2, 0, 0);
    join
    check("wr_before_rd", 64'(rd_hs_cyc - wr_hs_cyc), 64'd1);
    axil_read(12'h028, 32'd77, 2, 0, 0);

    axil_write(12'h000, 32'h1);
    pulse_done();
    @(posedge clk); #1 axil.araddr = 12'h020; axil.arvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (axil.arready) seen = 1'b1;
    end
    check("pre_reset_ar", 64'(seen), 64'd1);
    @(posedge clk); #1 axil.arvalid = 1'b0; axis_rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset", {28'd0, axil.rvalid, axil.arready, tap_EN, ap_start_o, data_length_o}, 64'd0);
    @(posedge clk); #1 axis_rst_n = 1'b0;
    axil_read(12'h000, 32'h4, 1, 0, 0);
    axil_read(12'h010, 32'h0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
